// File: rtl/native_fifo_spi_master.sv
// Pops command words from a non-show-ahead FIFO, shifts each out as a full-duplex
// SPI mode-0 frame (MSB first) and pushes the captured MISO word into a return FIFO.
module native_fifo_spi_master #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rdreq,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    input  logic                  rx_full,
    output logic                  rx_wrreq,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  spi_sclk,
    output logic                  spi_mosi,
    output logic                  spi_ssn,
    input  logic                  spi_miso,
    output logic                  busy
);

    localparam int HW = $clog2(CLK_DIV) + 1;
    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [HW-1:0] DIV_LAST = HW'(CLK_DIV - 1);
    localparam logic [HW-1:0] DIV_ONE  = HW'(1);
    localparam logic [BW-1:0] BIT_ALL  = BW'(DATA_WIDTH);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, SETUP, SHIFT, HOLD, GAP, WRBACK
    } state_t;

    state_t                state_r;
    logic [HW-1:0]         div_cnt_r;
    logic [BW-1:0]         bit_cnt_r;
    logic [DATA_WIDTH-1:0] tx_r;
    logic [DATA_WIDTH-1:0] rx_r;

    // Frame sequencer; every output is a register updated on state transitions.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_r    <= IDLE;
            div_cnt_r  <= '0;
            bit_cnt_r  <= '0;
            tx_r       <= '0;
            rx_r       <= '0;
            fifo_rdreq <= 1'b0;
            rx_wrreq   <= 1'b0;
            rx_data    <= '0;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b0;
            spi_ssn    <= 1'b1;
            busy       <= 1'b0;
        end else begin
            fifo_rdreq <= 1'b0;
            rx_wrreq   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (enable && !fifo_empty) begin
                        fifo_rdreq <= 1'b1;
                        busy       <= 1'b1;
                        state_r    <= FETCH;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    state_r <= LOAD;
                end
                LOAD: begin
                    tx_r      <= fifo_q;
                    rx_r      <= '0;
                    spi_ssn   <= 1'b0;
                    spi_sclk  <= 1'b0;
                    spi_mosi  <= fifo_q[DATA_WIDTH-1];
                    div_cnt_r <= '0;
                    state_r   <= SETUP;
                end
                SETUP: begin
                    if (div_cnt_r == DIV_LAST) begin
                        // First rising edge: MOSI has been stable for a full half-period.
                        div_cnt_r <= '0;
                        bit_cnt_r <= '0;
                        spi_sclk  <= 1'b1;
                        rx_r      <= {rx_r[DATA_WIDTH-2:0], spi_miso};
                        state_r   <= SHIFT;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                    end
                end
                SHIFT: begin
                    if (div_cnt_r != DIV_LAST) begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                    end else if (spi_sclk) begin
                        div_cnt_r <= '0;
                        spi_sclk  <= 1'b0;
                        tx_r      <= {tx_r[DATA_WIDTH-2:0], 1'b0};
                        spi_mosi  <= tx_r[DATA_WIDTH-2];
                        bit_cnt_r <= bit_cnt_r + BIT_ONE;
                    end else if (bit_cnt_r == BIT_ALL) begin
                        // Low phase after the last falling edge has elapsed.
                        div_cnt_r <= '0;
                        state_r   <= HOLD;
                    end else begin
                        div_cnt_r <= '0;
                        spi_sclk  <= 1'b1;
                        rx_r      <= {rx_r[DATA_WIDTH-2:0], spi_miso};
                    end
                end
                HOLD: begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r <= '0;
                        spi_ssn   <= 1'b1;
                        state_r   <= GAP;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                    end
                end
                GAP: begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r <= '0;
                        state_r   <= WRBACK;
                    end else begin
                        div_cnt_r <= div_cnt_r + DIV_ONE;
                    end
                end
                WRBACK: begin
                    if (!rx_full) begin
                        rx_data  <= rx_r;
                        rx_wrreq <= 1'b1;
                        busy     <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        state_r <= WRBACK;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    spi_ssn  <= 1'b1;
                    spi_sclk <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_native_fifo_spi_master.sv
// Self-checking bench: command FIFO model, SPI slave/monitor, table-driven frames
// plus burst, back-pressure, mid-frame reset and enable-gating sequences.
module tb_native_fifo_spi_master;

    localparam int DW = 32;
    localparam int CD = 4;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b1;
    logic          enable = 1'b0;
    logic          fifo_empty;
    logic          fifo_rdreq;
    logic [DW-1:0] fifo_q = '0;
    logic          rx_full = 1'b0;
    logic          rx_wrreq;
    logic [DW-1:0] rx_data;
    logic          spi_sclk;
    logic          spi_mosi;
    logic          spi_ssn;
    logic          spi_miso;
    logic          busy;

    logic          loop_mode = 1'b1;
    logic          miso_val = 1'b0;
    assign spi_miso = loop_mode ? spi_mosi : miso_val;

    native_fifo_spi_master #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_rdreq(fifo_rdreq), .fifo_q(fifo_q), .rx_full(rx_full), .rx_wrreq(rx_wrreq),
        .rx_data(rx_data), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ssn(spi_ssn),
        .spi_miso(spi_miso), .busy(busy)
    );

    always #5 ACLK = ~ACLK;

    // Non-show-ahead command FIFO model: data appears the cycle after rdreq.
    logic [DW-1:0] cmd_mem [0:31];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge ACLK) begin
        if (fifo_rdreq) begin
            fifo_q <= cmd_mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Monitor and SPI slave, sampled on the falling ACLK edge.
    int          rdreq_cnt = 0;
    int          rise_cnt = 0;
    int          low_len = 0;
    int          last_low = 0;
    int          high_len = 0;
    int          min_high = 1000000;
    int          stab = 0;
    int          min_stab = 1000000;
    logic        seen_frame = 1'b0;
    logic        prev_ssn = 1'b1;
    logic        prev_sclk = 1'b0;
    logic        prev_mosi = 1'b0;
    logic [DW-1:0] slave_sh = '0;
    logic [DW-1:0] wr_q[$];
    logic [DW-1:0] slave_q[$];

    always @(negedge ACLK) begin
        prev_ssn  <= spi_ssn;
        prev_sclk <= spi_sclk;
        prev_mosi <= spi_mosi;
        if (fifo_rdreq) rdreq_cnt <= rdreq_cnt + 1;
        if (rx_wrreq) wr_q.push_back(rx_data);
        if (spi_mosi != prev_mosi) stab <= 0;
        else stab <= stab + 1;
        if (spi_sclk && !prev_sclk) begin
            rise_cnt <= rise_cnt + 1;
            slave_sh <= {slave_sh[DW-2:0], spi_mosi};
            if (spi_mosi != prev_mosi) min_stab <= 0;
            else if (stab + 1 < min_stab) min_stab <= stab + 1;
        end
        if (!spi_ssn) begin
            if (prev_ssn) begin
                if (seen_frame && high_len < min_high) min_high <= high_len;
                low_len <= 1;
            end else begin
                low_len <= low_len + 1;
            end
        end else begin
            if (!prev_ssn) begin
                last_low <= low_len;
                slave_q.push_back(slave_sh);
                seen_frame <= 1'b1;
                high_len <= 1;
            end else begin
                high_len <= high_len + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge ACLK);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        cmd_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_wr(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (wr_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk(name, 32'(wr_q.size() >= n), 32'd1);
    endtask

    typedef struct packed {
        logic [DW-1:0] word;
        logic          loop;
        logic          miso;
        logic [DW-1:0] exp_rx;
    } vec_t;

    vec_t vecs [0:4];

    initial begin
        int base_wr;
        int base_rd;
        int base_rise;
        int base_sl;
        int k;

        vecs[0] = '{word: 32'hA5A5_0F0F, loop: 1'b1, miso: 1'b0, exp_rx: 32'hA5A5_0F0F};
        vecs[1] = '{word: 32'h0000_0000, loop: 1'b0, miso: 1'b1, exp_rx: 32'hFFFF_FFFF};
        vecs[2] = '{word: 32'hFFFF_FFFF, loop: 1'b0, miso: 1'b0, exp_rx: 32'h0000_0000};
        vecs[3] = '{word: 32'h1234_5678, loop: 1'b1, miso: 1'b0, exp_rx: 32'h1234_5678};
        vecs[4] = '{word: 32'h8000_0001, loop: 1'b0, miso: 1'b1, exp_rx: 32'hFFFF_FFFF};

        #1 ARESETN = 1'b0;
        repeat (3) step();
        chk("rst_rdreq", 32'(fifo_rdreq), 32'd0);
        chk("rst_wrreq", 32'(rx_wrreq), 32'd0);
        chk("rst_rx_data", rx_data, 32'd0);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_ssn", 32'(spi_ssn), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        ARESETN = 1'b1;
        enable = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            loop_mode = vecs[i].loop;
            miso_val  = vecs[i].miso;
            base_wr   = wr_q.size();
            base_rd   = rdreq_cnt;
            base_rise = rise_cnt;
            push(vecs[i].word);
            wait_wr(base_wr + 1, 400, $sformatf("v%0d_timeout", i));
            if (wr_q.size() > base_wr) chk($sformatf("v%0d_rx", i), wr_q[base_wr], vecs[i].exp_rx);
            if (slave_q.size() > 0) chk($sformatf("v%0d_slave", i), slave_q[slave_q.size()-1], vecs[i].word);
            chk($sformatf("v%0d_rdreq", i), 32'(rdreq_cnt - base_rd), 32'd1);
            chk($sformatf("v%0d_rises", i), 32'(rise_cnt - base_rise), 32'd32);
            chk($sformatf("v%0d_ssn_low", i), 32'(last_low), 32'd264);
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
            repeat (3) step();
        end
        chk("mosi_setup", 32'(min_stab >= CD), 32'd1);

        // Burst of three back-to-back words in loopback.
        loop_mode = 1'b1;
        base_wr = wr_q.size();
        base_rd = rdreq_cnt;
        base_sl = slave_q.size();
        push(32'h1); push(32'h2); push(32'h3);
        wait_wr(base_wr + 3, 1200, "burst_timeout");
        for (int j = 0; j < 3; j++) begin
            if (wr_q.size() > base_wr + j)
                chk($sformatf("burst_rx%0d", j), wr_q[base_wr + j], 32'(j + 1));
            if (slave_q.size() > base_sl + j)
                chk($sformatf("burst_slave%0d", j), slave_q[base_sl + j], 32'(j + 1));
        end
        chk("burst_rdreq", 32'(rdreq_cnt - base_rd), 32'd3);
        chk("burst_gap", 32'(min_high >= CD + 2), 32'd1);
        repeat (10) step();
        chk("rx_data_hold", rx_data, 32'h3);

        // Back-pressure on the return FIFO.
        rx_full = 1'b1;
        base_wr = wr_q.size();
        base_rd = rdreq_cnt;
        base_sl = slave_q.size();
        push(32'hCAFE_0001); push(32'hCAFE_0002);
        k = 0;
        while (slave_q.size() < base_sl + 1 && k < 400) begin step(); k++; end
        chk("bp_frame_timeout", 32'(slave_q.size() > base_sl), 32'd1);
        repeat (100) step();
        chk("bp_no_wr", 32'(wr_q.size() - base_wr), 32'd0);
        chk("bp_busy", 32'(busy), 32'd1);
        chk("bp_ssn", 32'(spi_ssn), 32'd1);
        chk("bp_no_rdreq", 32'(rdreq_cnt - base_rd), 32'd1);
        rx_full = 1'b0;
        step();
        chk("bp_wrreq", 32'(rx_wrreq), 32'd1);
        chk("bp_rx", rx_data, 32'hCAFE_0001);
        wait_wr(base_wr + 2, 400, "bp_second_timeout");
        if (wr_q.size() > base_wr + 1) chk("bp_rx2", wr_q[base_wr + 1], 32'hCAFE_0002);
        chk("bp_rdreq2", 32'(rdreq_cnt - base_rd), 32'd2);
        repeat (3) step();

        // Asynchronous reset in the middle of SHIFT.
        base_rise = rise_cnt;
        push(32'h0F0F_1234);
        k = 0;
        while (rise_cnt < base_rise + 10 && k < 300) begin step(); k++; end
        chk("rs_rise_timeout", 32'(rise_cnt >= base_rise + 10), 32'd1);
        ARESETN = 1'b0;
        #1;
        chk("rs_ssn", 32'(spi_ssn), 32'd1);
        chk("rs_sclk", 32'(spi_sclk), 32'd0);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_rx_data", rx_data, 32'd0);
        step();
        ARESETN = 1'b1;
        base_wr = wr_q.size();
        base_rd = rdreq_cnt;
        repeat (50) step();
        chk("rs_idle_rdreq", 32'(rdreq_cnt - base_rd), 32'd0);
        chk("rs_idle_wr", 32'(wr_q.size() - base_wr), 32'd0);
        chk("rs_idle_busy", 32'(busy), 32'd0);

        // Enable gating, then enable dropped mid-frame.
        enable = 1'b0;
        base_wr = wr_q.size();
        base_rd = rdreq_cnt;
        push(32'h3C3C_0001); push(32'h3C3C_0002);
        repeat (50) step();
        chk("en_off_rdreq", 32'(rdreq_cnt - base_rd), 32'd0);
        chk("en_off_busy", 32'(busy), 32'd0);
        base_rise = rise_cnt;
        enable = 1'b1;
        k = 0;
        while (rise_cnt < base_rise + 5 && k < 100) begin step(); k++; end
        chk("en_rise_timeout", 32'(rise_cnt >= base_rise + 5), 32'd1);
        enable = 1'b0;
        wait_wr(base_wr + 1, 400, "en_wr_timeout");
        if (wr_q.size() > base_wr) chk("en_rx", wr_q[base_wr], 32'h3C3C_0001);
        repeat (100) step();
        chk("en_rdreq", 32'(rdreq_cnt - base_rd), 32'd1);
        chk("en_wr", 32'(wr_q.size() - base_wr), 32'd1);
        chk("en_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
